cart_backup_ctrl: RTL and testbench

- Sits downstream of the cartridge mappers: consumes the shared `has_battery`, `ram_enabled`, `ram_mask` and cart-RAM write strobe.
- Moves battery-backed cart RAM to and from the mounted save image over the host SD block interface.
- Tracks a dirty flag, sequences 512-byte block transfers and raises `bk_busy` so the top level pauses the CPU during loads.

---
 rtl/cart_pkg.sv | 43 ++++
 rtl/cart_backup_ctrl_edge_rise.sv | 30 +++
 rtl/cart_backup_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_cart_backup_ctrl.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cart_pkg.sv
// ---------------------------------------------------------------------------
// cart_pkg
// Shared definitions for the cartridge backup-RAM controller:
//   - bk_state_e  : transfer FSM states
//   - BLOCK_BYTES : size of one host SD block (512 bytes)
//   - BUF_AW      : width of the byte index inside one block
//   - BLK_W       : width of the block counter (up to 256 blocks)
//   - block_count : number of blocks for a cart-RAM size code
//   - last_block  : index of the final block for a cart-RAM size code
// ---------------------------------------------------------------------------
package cart_pkg;

    localparam int BLOCK_BYTES = 512;
    localparam int BUF_AW      = $clog2(BLOCK_BYTES);
    localparam int BLK_W       = 8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_ACK  = 3'd2,
        ST_DONE = 3'd3,
        ST_NEXT = 3'd4
    } bk_state_e;

    // Size code 0..3 selects 512 B, 8 KB, 32 KB or 128 KB of cart RAM.
    function automatic logic [BLK_W:0] block_count(input logic [1:0] mask);
        logic [BLK_W:0] n;
        case (mask)
            2'd0:    n = 9'd1;
            2'd1:    n = 9'd16;
            2'd2:    n = 9'd64;
            default: n = 9'd256;
        endcase
        return n;
    endfunction

    function automatic logic [BLK_W-1:0] last_block(input logic [1:0] mask);
        logic [BLK_W:0] n;
        n = block_count(mask) - 9'd1;
        return n[BLK_W-1:0];
    endfunction

endpackage

// File: rtl/cart_backup_ctrl_edge_rise.sv
// ---------------------------------------------------------------------------
// edge_rise
// Single-flop rising-edge detector. The output is combinational from the
// input, so a trigger is seen in the same cycle the input goes high.
// Ports:
//   clk_i  : clock
//   rst_i  : asynchronous active-high reset (history flop cleared)
//   d_i    : level input
//   rise_o : one-cycle pulse when d_i is high and was low last cycle
// ---------------------------------------------------------------------------
module edge_rise (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic rise_o
);

    logic d_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d_i;
        end
    end

    assign rise_o = d_i & ~d_q;

endmodule

// File: rtl/cart_backup_ctrl.sv
// ---------------------------------------------------------------------------
// cart_backup_ctrl
// Moves battery-backed cartridge RAM to and from the mounted save image using
// the host SD block interface, 512 bytes per block. A load starts when an
// image is mounted; a save starts on a user request when there are unsaved
// cart-RAM writes. bk_busy is high for the whole transfer so the top level
// can hold the CPU during loads.
//
// Optional build macro: CART_BACKUP_AUTOSAVE_EN
//   Defined   : an idle counter reloads to AUTOSAVE_CYCLES on every cart-RAM
//               write and counts down while dirty and idle; reaching zero
//               acts like a bk_save edge.
//   Undefined : saves happen only on bk_save.
//
// Ports:
//   clk_sys, reset        : clock, asynchronous active-high reset
//   has_battery, ram_mask : active mapper's battery flag and RAM size code
//   cram_wr               : CPU wrote cart RAM (one-cycle strobe)
//   img_mounted           : save image mounted (level)
//   img_size_nz           : mounted image is non-empty
//   bk_save               : user save request (level, edge-detected)
//   sd_lba/sd_rd/sd_wr    : block request to the host
//   sd_ack                : host transfer window
//   sd_buff_addr/_dout/_wr: host byte stream (load)
//   sd_buff_din           : byte stream to host (save), equals bk_q
//   bk_addr/bk_data/bk_wr : backup RAM write port
//   bk_q                  : backup RAM read data (1-cycle latency)
//   bk_busy, bk_dirty     : transfer in progress, unsaved writes exist
// ---------------------------------------------------------------------------
module cart_backup_ctrl
    import cart_pkg::*;
#(
    parameter int          ADDR_W          = 17,
    parameter logic [31:0] AUTOSAVE_CYCLES = 32'd67108864
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              has_battery,
    input  logic [1:0]        ram_mask,
    input  logic              cram_wr,
    input  logic              img_mounted,
    input  logic              img_size_nz,
    input  logic              bk_save,
    output logic [31:0]       sd_lba,
    output logic              sd_rd,
    output logic              sd_wr,
    input  logic              sd_ack,
    input  logic [8:0]        sd_buff_addr,
    input  logic [7:0]        sd_buff_dout,
    input  logic              sd_buff_wr,
    output logic [7:0]        sd_buff_din,
    output logic [ADDR_W-1:0] bk_addr,
    output logic [7:0]        bk_data,
    output logic              bk_wr,
    input  logic [7:0]        bk_q,
    output logic              bk_busy,
    output logic              bk_dirty
);

    bk_state_e              state_q, state_d;
    logic [BLK_W-1:0]       blk_q, blk_d;
    logic                   load_q, load_d;
    logic                   dirty_q, dirty_d;
    logic                   dirty_clr;
    logic                   mount_rise;
    logic                   save_rise;
    logic                   auto_fire;
    logic                   load_trig;
    logic                   save_trig;
    logic [BLK_W+BUF_AW-1:0] addr_full;

    edge_rise u_mount_edge (
        .clk_i  (clk_sys),
        .rst_i  (reset),
        .d_i    (img_mounted),
        .rise_o (mount_rise)
    );

    edge_rise u_save_edge (
        .clk_i  (clk_sys),
        .rst_i  (reset),
        .d_i    (bk_save),
        .rise_o (save_rise)
    );

    // Both triggers only matter in IDLE; load has priority there, and the
    // save edge, being a single-cycle pulse, is simply lost.
    assign load_trig = mount_rise & has_battery & img_size_nz;
    assign save_trig = (save_rise | auto_fire) & has_battery & dirty_q & img_mounted;

`ifdef CART_BACKUP_AUTOSAVE_EN
    logic [31:0] idle_cnt_q, idle_cnt_d;

    always_comb begin
        idle_cnt_d = idle_cnt_q;
        if (cram_wr) begin
            idle_cnt_d = AUTOSAVE_CYCLES;
        end else if (dirty_q && (state_q == ST_IDLE) && (idle_cnt_q != 32'd0)) begin
            idle_cnt_d = idle_cnt_q - 32'd1;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            idle_cnt_q <= 32'd0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
        end
    end

    // Dirty implies a write has reloaded the counter, so a zero count while
    // dirty means the full idle interval has elapsed.
    assign auto_fire = dirty_q & (state_q == ST_IDLE) & (idle_cnt_q == 32'd0);
`else
    logic autosave_unused;
    assign autosave_unused = ^AUTOSAVE_CYCLES;
    assign auto_fire       = 1'b0;
`endif

    // Transfer FSM: next state and counter.
    always_comb begin
        state_d   = state_q;
        blk_d     = blk_q;
        load_d    = load_q;
        dirty_clr = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (load_trig) begin
                    state_d   = ST_REQ;
                    load_d    = 1'b1;
                    dirty_clr = 1'b1;
                end else if (save_trig) begin
                    state_d   = ST_REQ;
                    load_d    = 1'b0;
                    dirty_clr = 1'b1;
                end
            end
            ST_REQ: begin
                if (sd_ack) begin
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                if (!sd_ack) begin
                    state_d = ST_NEXT;
                end
            end
            ST_NEXT: begin
                // Terminal compare against N-1; the 8-bit counter never
                // needs to roll over on its own.
                if (blk_q == last_block(ram_mask)) begin
                    state_d = ST_DONE;
                end else begin
                    blk_d   = blk_q + 8'd1;
                    state_d = ST_REQ;
                end
            end
            ST_DONE: begin
                blk_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                blk_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // A cart-RAM write in the same cycle as a save entry must survive the
    // clear, otherwise that write would never be saved.
    always_comb begin
        dirty_d = dirty_q;
        if (dirty_clr) begin
            dirty_d = 1'b0;
        end
        if (cram_wr && has_battery) begin
            dirty_d = 1'b1;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            blk_q   <= '0;
            load_q  <= 1'b0;
            dirty_q <= 1'b0;
        end else begin
            state_q <= state_d;
            blk_q   <= blk_d;
            load_q  <= load_d;
            dirty_q <= dirty_d;
        end
    end

    // Requests are decoded from the state register, so an async reset drops
    // them immediately and the host sees the block abandoned.
    assign bk_busy     = (state_q != ST_IDLE);
    assign sd_rd       = (state_q == ST_REQ) &  load_q;
    assign sd_wr       = (state_q == ST_REQ) & ~load_q;
    assign sd_lba      = {{(32-BLK_W){1'b0}}, blk_q};

    assign addr_full   = {blk_q, sd_buff_addr};
    assign bk_addr     = ADDR_W'(addr_full);
    assign bk_data     = sd_buff_dout;
    assign bk_wr       = sd_buff_wr & sd_ack & load_q & bk_busy;
    assign sd_buff_din = bk_q;
    assign bk_dirty    = dirty_q;

endmodule

// File: tb/tb_cart_backup_ctrl.sv
`timescale 1ns/1ps
module tb_cart_backup_ctrl;

    localparam int ADDR_W = 17;

    logic              clk_sys = 1'b0;
    logic              reset = 1'b1;
    logic              has_battery = 1'b0;
    logic [1:0]        ram_mask = 2'd0;
    logic              cram_wr = 1'b0;
    logic              img_mounted = 1'b0;
    logic              img_size_nz = 1'b0;
    logic              bk_save = 1'b0;
    logic [31:0]       sd_lba;
    logic              sd_rd;
    logic              sd_wr;
    logic              sd_ack = 1'b0;
    logic [8:0]        sd_buff_addr = 9'd0;
    logic [7:0]        sd_buff_dout = 8'd0;
    logic              sd_buff_wr = 1'b0;
    logic [7:0]        sd_buff_din;
    logic [ADDR_W-1:0] bk_addr;
    logic [7:0]        bk_data;
    logic              bk_wr;
    logic [7:0]        bk_q;
    logic              bk_busy;
    logic              bk_dirty;

    always #5 clk_sys = ~clk_sys;

    cart_backup_ctrl #(
        .ADDR_W          (ADDR_W),
        .AUTOSAVE_CYCLES (32'd100)
    ) dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .has_battery  (has_battery),
        .ram_mask     (ram_mask),
        .cram_wr      (cram_wr),
        .img_mounted  (img_mounted),
        .img_size_nz  (img_size_nz),
        .bk_save      (bk_save),
        .sd_lba       (sd_lba),
        .sd_rd        (sd_rd),
        .sd_wr        (sd_wr),
        .sd_ack       (sd_ack),
        .sd_buff_addr (sd_buff_addr),
        .sd_buff_dout (sd_buff_dout),
        .sd_buff_wr   (sd_buff_wr),
        .sd_buff_din  (sd_buff_din),
        .bk_addr      (bk_addr),
        .bk_data      (bk_data),
        .bk_wr        (bk_wr),
        .bk_q         (bk_q),
        .bk_busy      (bk_busy),
        .bk_dirty     (bk_dirty)
    );

    // Backup RAM with one-cycle read latency.
    logic [7:0] ram [0:(1<<ADDR_W)-1];
    always @(posedge clk_sys) begin
        if (bk_wr) ram[bk_addr] <= bk_data;
        bk_q <= ram[bk_addr];
    end

    // Reference image contents: key = block*512 + byte index.
    logic [7:0] ref_mem [int];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic pulse_wr();
        cram_wr = 1'b1;
        @(negedge clk_sys);
        cram_wr = 1'b0;
    endtask

    // Blocks per image derived from the cart-RAM size in bytes.
    function automatic int nblocks(input int mask);
        int bytes;
        case (mask)
            0:       bytes = 512;
            1:       bytes = 8192;
            2:       bytes = 32768;
            default: bytes = 131072;
        endcase
        return bytes / 512;
    endfunction

    function automatic logic [8:0] pick_addr();
        case ($urandom_range(0, 3))
            0:       return 9'h000;
            1:       return 9'h001;
            2:       return 9'h100;
            default: return 9'h1FF;
        endcase
    endfunction

    // Host model: serves block requests until bk_busy drops. Returns the
    // number of blocks served and the negedges from the last ack fall to
    // bk_busy low. Stops without acking when block stop_at is requested.
    task automatic serve(input bit is_load, input int stop_at, input bit a5,
                         input bit wr_mid, output int got, output int tail);
        int guard;
        int since;
        int key;
        logic [8:0] a;
        logic [7:0] d;
        got = 0; tail = -1; guard = 0; since = -1;
        forever begin
            @(negedge clk_sys);
            guard++;
            if (since >= 0) since++;
            if (!bk_busy) begin
                tail = since;
                break;
            end
            if (guard > 8000) begin
                chk("serve_timeout", guard, 0);
                break;
            end
            if (sd_rd || sd_wr) begin
                if (got == stop_at) break;
                chk("req_dir_rd", sd_rd, is_load);
                chk("req_lba", sd_lba, got);
                sd_ack = 1'b1;
                @(negedge clk_sys);
                guard++;
                chk("req_drop", sd_rd | sd_wr, 0);
                for (int k = 0; k < 2; k++) begin
                    a = pick_addr();
                    key = int'({got[7:0], a});
                    if (is_load) begin
                        d = 8'($urandom);
                        sd_buff_addr = a; sd_buff_dout = d; sd_buff_wr = 1'b1;
                        #1;
                        chk("load_bk_wr", bk_wr, 1);
                        chk("load_bk_addr", bk_addr, key);
                        @(negedge clk_sys);
                        sd_buff_wr = 1'b0;
                        ref_mem[key] = d;
                    end else begin
                        sd_buff_addr = a;
                        @(negedge clk_sys);
                        if (ref_mem.exists(key)) chk("save_byte", sd_buff_din, ref_mem[key]);
                    end
                end
                if (a5 && is_load && got == 3) begin
                    sd_buff_addr = 9'h1FF; sd_buff_dout = 8'hA5; sd_buff_wr = 1'b1;
                    #1;
                    chk("a5_wr", bk_wr, 1);
                    chk("a5_addr", bk_addr, 17'h007FF);
                    chk("a5_data", bk_data, 8'hA5);
                    @(negedge clk_sys);
                    sd_buff_wr = 1'b0;
                    ref_mem[32'h7FF] = 8'hA5;
                end
                if (wr_mid) pulse_wr();
                sd_ack = 1'b0;
                got++;
                since = 0;
            end
        end
    endtask

    typedef struct {
        logic [1:0] mask;
        bit         batt;
        bit         nz;
        int         exp_n;
    } vec_t;

    vec_t vecs [6];

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int got, tail, cnt, mdirty;
        bit batt, nz;
        int mask;

        vecs[0] = '{2'd0, 1'b1, 1'b1, 1};
        vecs[1] = '{2'd1, 1'b1, 1'b1, 16};
        vecs[2] = '{2'd2, 1'b1, 1'b1, 64};
        vecs[3] = '{2'd3, 1'b1, 1'b1, 256};
        vecs[4] = '{2'd1, 1'b0, 1'b1, 0};
        vecs[5] = '{2'd1, 1'b1, 1'b0, 0};

        // Reset state
        tick(3);
        chk("rst_sd_rd", sd_rd, 0);
        chk("rst_sd_wr", sd_wr, 0);
        chk("rst_busy", bk_busy, 0);
        chk("rst_dirty", bk_dirty, 0);
        chk("rst_lba", sd_lba, 0);
        chk("rst_bk_wr", bk_wr, 0);
        reset = 1'b0;
        tick(2);

        // Load of 16 blocks with A5 at block 3 byte 1FF.
        has_battery = 1'b1; img_size_nz = 1'b1; ram_mask = 2'd1;
        img_mounted = 1'b1;
        serve(1'b1, -1, 1'b1, 1'b0, got, tail);
        chk("load16_blocks", got, 16);
        // ack falls -> ACK sees it, NEXT, DONE, then IDLE
        chk("load16_busy_tail", tail, 3);
        chk("ram_a5", ram[17'h7FF], 8'hA5);

        // Table-driven load vectors.
        foreach (vecs[i]) begin
            img_mounted = 1'b0;
            tick(1);
            ram_mask = vecs[i].mask; has_battery = vecs[i].batt; img_size_nz = vecs[i].nz;
            img_mounted = 1'b1;
            serve(1'b1, -1, 1'b0, 1'b0, got, tail);
            chk($sformatf("vec%0d_blocks", i), got, vecs[i].exp_n);
            chk($sformatf("vec%0d_idle", i), bk_busy, 0);
        end
        has_battery = 1'b1; img_size_nz = 1'b1;

        // Save with ram_mask 0.
        ram_mask = 2'd0;
        pulse_wr();
        chk("save_dirty_set", bk_dirty, 1);
        bk_save = 1'b1;
        @(negedge clk_sys);
        chk("save_entry_dirty", bk_dirty, 0);
        chk("save_entry_wr", sd_wr, 1);
        serve(1'b0, -1, 1'b0, 1'b0, got, tail);
        chk("save_blocks", got, 1);
        chk("save_dirty_after", bk_dirty, 0);
        bk_save = 1'b0;
        tick(2);

        // Save request while clean does nothing.
        bk_save = 1'b1;
        serve(1'b0, -1, 1'b0, 1'b0, got, tail);
        chk("clean_save_blocks", got, 0);
        chk("clean_busy", bk_busy, 0);
        bk_save = 1'b0;
        tick(2);

        // Write in the same cycle as save entry, then write mid-save.
        pulse_wr();
        bk_save = 1'b1; cram_wr = 1'b1;
        @(negedge clk_sys);
        cram_wr = 1'b0;
        chk("same_cycle_dirty", bk_dirty, 1);
        serve(1'b0, -1, 1'b0, 1'b0, got, tail);
        chk("same_cycle_blocks", got, 1);
        chk("same_cycle_dirty_after", bk_dirty, 1);
        bk_save = 1'b0;
        tick(2);
        bk_save = 1'b1;
        serve(1'b0, -1, 1'b0, 1'b1, got, tail);
        chk("mid_save_blocks", got, 1);
        chk("mid_save_dirty_after", bk_dirty, 1);
        bk_save = 1'b0;
        tick(2);

        // Mount and save edge together: load only.
        img_mounted = 1'b0;
        tick(1);
        img_mounted = 1'b1; bk_save = 1'b1;
        serve(1'b1, -1, 1'b0, 1'b0, got, tail);
        chk("mount_save_load_blocks", got, 1);
        chk("mount_save_dirty", bk_dirty, 0);
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk_sys);
            if (sd_wr || bk_busy) cnt++;
        end
        chk("mount_save_no_save", cnt, 0);
        bk_save = 1'b0;
        tick(2);

        // Randomized operations against a dirty-flag / block-count model.
        mdirty = 0;
        for (int it = 0; it < 30; it++) begin
            case ($urandom_range(0, 3))
                0: begin
                    batt = ($urandom_range(0, 3) != 0);
                    has_battery = batt;
                    pulse_wr();
                    if (batt) mdirty = 1;
                    has_battery = 1'b1;
                end
                1: begin
                    mask = $urandom_range(0, 2);
                    batt = ($urandom_range(0, 3) != 0);
                    ram_mask = 2'(mask); has_battery = batt;
                    bk_save = 1'b1;
                    serve(1'b0, -1, 1'b0, 1'b0, got, tail);
                    chk("rnd_save_blocks", got, (batt && mdirty != 0) ? nblocks(mask) : 0);
                    if (batt) mdirty = 0;
                    bk_save = 1'b0; has_battery = 1'b1;
                    tick(1);
                end
                2: begin
                    mask = $urandom_range(0, 2);
                    batt = ($urandom_range(0, 3) != 0);
                    nz = ($urandom_range(0, 3) != 0);
                    img_mounted = 1'b0;
                    tick(1);
                    ram_mask = 2'(mask); has_battery = batt; img_size_nz = nz;
                    img_mounted = 1'b1;
                    serve(1'b1, -1, 1'b0, 1'b0, got, tail);
                    chk("rnd_load_blocks", got, (batt && nz) ? nblocks(mask) : 0);
                    if (batt && nz) mdirty = 0;
                    has_battery = 1'b1; img_size_nz = 1'b1;
                    tick(1);
                end
                default: tick($urandom_range(1, 5));
            endcase
            chk("rnd_dirty", bk_dirty, mdirty);
        end

        // Async reset during block 5 of 16.
        ram_mask = 2'd1; has_battery = 1'b1; img_size_nz = 1'b1;
        img_mounted = 1'b0;
        tick(1);
        img_mounted = 1'b1;
        serve(1'b1, 5, 1'b0, 1'b0, got, tail);
        chk("rst_mid_block", got, 5);
        chk("rst_mid_rd_before", sd_rd, 1);
        chk("rst_mid_lba_before", sd_lba, 5);
        reset = 1'b1; img_mounted = 1'b0;
        #1;
        chk("rst_mid_rd", sd_rd, 0);
        chk("rst_mid_busy", bk_busy, 0);
        chk("rst_mid_lba", sd_lba, 0);
        @(negedge clk_sys);
        chk("rst_mid_rd_next", sd_rd, 0);
        chk("rst_mid_busy_next", bk_busy, 0);
        reset = 1'b0;
        tick(2);

        // Idle after a write: autosave only when the feature is built in.
        ram_mask = 2'd0;
        img_mounted = 1'b1;
        serve(1'b1, -1, 1'b0, 1'b0, got, tail);
        chk("post_rst_load", got, 1);
        pulse_wr();
`ifdef CART_BACKUP_AUTOSAVE_EN
        cnt = 0;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk_sys);
            if (sd_wr) begin
                cnt = k;
                break;
            end
        end
        chk($sformatf("autosave_delay_%0d", cnt), (cnt >= 98 && cnt <= 106), 1);
        serve(1'b0, -1, 1'b0, 1'b0, got, tail);
        chk("autosave_blocks", got, 1);
        chk("autosave_dirty", bk_dirty, 0);
`else
        cnt = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk_sys);
            if (sd_wr) cnt++;
        end
        chk("no_autosave", cnt, 0);
        chk("no_autosave_dirty", bk_dirty, 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
